paddsb_16bit: RTL and testbench
===============================

Name: paddsb_16bit

Overview:
- Packed 4-bit signed saturating add/subtract unit for the Execute stage (PADDSB instruction).
- Treats each 16-bit operand as four independent two's-complement nibbles (lanes).
- Each lane is added or subtracted with no carry between lanes. Each lane result saturates to +7/-8 on overflow.
- The result is registered: one clock of latency, with a valid strobe.

Parameters:
- LANE_W, 4, width of one signed lane. Only 4 is required to work.
- LANES, 4, number of lanes. Data width = LANE_W*LANES = 16.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands valid this cycle.
- a  input  16  operand A, lanes [3:0],[7:4],[11:8],[15:12].
- b  input  16  operand B, same lane packing.
- sub  input  1  0 = A+B per lane, 1 = A-B per lane.
- out_valid  output  1  sum holds the result of the operation issued on the previous cycle.
- sum  output  16  packed saturated lane results.

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset values: sum=16'h0000, out_valid=0. Reset asserted alongside in_valid discards the operation.
- Latency and capture:
  - Latency is exactly 1 cycle. On a rising edge with rst_n=1 and in_valid=1, sum <= f(a,b,sub) and out_valid <= 1.
  - A back-to-back in_valid stream gives one result per cycle.
- Idle: in_valid=0 (rst_n=1) gives out_valid <= 0, and sum holds its previous value.
- Per-lane arithmetic, lane i = bits [4i+3:4i]:
  - Operands are signed 4-bit, range -8..+7.
  - Exact result r = a_i + b_i (sub=0) or a_i - b_i (sub=1), computed at 5+ bits signed.
  - r > 7 gives 4'h7. r < -8 gives 4'h8. Otherwise r[3:0].
  - Equivalent overflow rule on a 4-bit result using b' = sub ? ~b_i+1 : b_i:
    - For add, overflow iff sign(a) == sign(b) and sign(res) != sign(a).
    - For sub, overflow iff sign(a) != sign(b) and sign(res) != sign(a).
    - Overflow clamps toward the sign of a.
  - Subtracting 4'h8 (-8) must be handled correctly: 0 - (-8) = +8 saturates to 4'h7.
- No carry or borrow ever crosses a lane boundary. Lanes are fully independent.
- No other state. No handshake back-pressure: the block always accepts input.

Optional Feature:
- Macro PADDSB_SAT_FLAGS_EN.
- Defined:
  - Adds output port sat_flags[3:0], with bit i=1 when lane i saturated in the registered result.
  - sat_flags is registered with sum, resets to 0, and holds its value when in_valid=0.
  - Also adds output any_sat = |sat_flags.
- Not defined: the ports are absent and behaviour is otherwise identical.

Test Plan:
- Reset:
  - Hold rst_n=0 for 2 cycles with in_valid=1, a=16'h7777 -> sum=16'h0000, out_valid=0.
  - Release reset -> first result appears 1 cycle after the first in_valid.
- Plain add: sub=0, a=16'h1234, b=16'h1111 -> next cycle sum=16'h2345, out_valid=1, no saturation.
- Add saturation:
  - sub=0, a=16'h7777, b=16'h1111 -> sum=16'h7777 (positive clamp).
  - a=16'h8888, b=16'h8888 -> sum=16'h8888 (negative clamp).
  - Flags = 4'hF when PADDSB_SAT_FLAGS_EN is defined.
- Plain sub: sub=1, a=16'h4444, b=16'h1111 -> sum=16'h3333.
- Sub saturation:
  - sub=1, a=16'h7777, b=16'h8888 -> sum=16'h7777.
  - a=16'h8888, b=16'h7777 -> sum=16'h8888.
  - a=16'h0000, b=16'h8888 -> sum=16'h7777.
- Lane isolation and idle:
  - sub=0, a=16'h7F01, b=16'h1F0F.
  - Lanes hi->lo: 7+1 sat 7; F+F=-2 E; 0+0=0; 1+F=0 -> sum=16'h7E00, no cross-lane carry.
  - Then drop in_valid -> out_valid=0 and sum holds 16'h7E00.

Source files
------------

// File: rtl/paddsb_16bit_if.sv
// Operand/result bus for the packed 4-bit signed saturating add/sub unit.
// PADDSB_SAT_FLAGS_EN adds the per-lane saturation flags and their OR.
interface paddsb_16bit_if #(
   parameter int LANE_W = 4,
   parameter int LANES  = 4
);
   localparam int DATA_W = LANE_W * LANES;

   logic              in_valid;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic              sub;
   logic              out_valid;
   logic [DATA_W-1:0] sum;
`ifdef PADDSB_SAT_FLAGS_EN
   logic [LANES-1:0]  sat_flags;
   logic              any_sat;

   modport master (
      output in_valid, a, b, sub,
      input  out_valid, sum, sat_flags, any_sat
   );

   modport slave (
      input  in_valid, a, b, sub,
      output out_valid, sum, sat_flags, any_sat
   );
`else
   modport master (
      output in_valid, a, b, sub,
      input  out_valid, sum
   );

   modport slave (
      input  in_valid, a, b, sub,
      output out_valid, sum
   );
`endif
endinterface

// File: rtl/paddsb_16bit.sv
// PADDSB execute unit: lane-wise signed saturating add/sub, one cycle of latency.
// Optional registered saturation flags when PADDSB_SAT_FLAGS_EN is defined.
module paddsb_16bit #(
   parameter int LANE_W = 4,
   parameter int LANES  = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   paddsb_16bit_if.slave  bus
);
   localparam int DATA_W = LANE_W * LANES;
   localparam int MSB    = LANE_W - 1;

   localparam logic [LANE_W-1:0] LANE_ONE = LANE_W'(1);
   localparam logic [LANE_W-1:0] LANE_MAX = {1'b0, {(LANE_W-1){1'b1}}};
   localparam logic [LANE_W-1:0] LANE_MIN = {1'b1, {(LANE_W-1){1'b0}}};

   // Overflow judged on the wrapped lane result; b is the original operand,
   // so negating the most-negative value (-8 -> -8) is still classified right.
   function automatic logic lane_ovf(
      input logic [LANE_W-1:0] a_l,
      input logic [LANE_W-1:0] b_l,
      input logic              sub_l
   );
      logic [LANE_W-1:0] b_eff;
      logic [LANE_W-1:0] res;
      b_eff = sub_l ? (~b_l + LANE_ONE) : b_l;
      res   = a_l + b_eff;
      if (sub_l) begin
         return (a_l[MSB] != b_l[MSB]) && (res[MSB] != a_l[MSB]);
      end
      return (a_l[MSB] == b_l[MSB]) && (res[MSB] != a_l[MSB]);
   endfunction

   function automatic logic [LANE_W-1:0] lane_sat(
      input logic [LANE_W-1:0] a_l,
      input logic [LANE_W-1:0] b_l,
      input logic              sub_l
   );
      logic [LANE_W-1:0] b_eff;
      b_eff = sub_l ? (~b_l + LANE_ONE) : b_l;
      // On overflow the true result lies beyond the range on a's side.
      if (lane_ovf(a_l, b_l, sub_l)) begin
         return a_l[MSB] ? LANE_MIN : LANE_MAX;
      end
      return a_l + b_eff;
   endfunction

   logic [DATA_W-1:0] sum_d, sum_q;
   logic              valid_d, valid_q;
`ifdef PADDSB_SAT_FLAGS_EN
   logic [LANES-1:0]  sat_d, sat_q;
`endif

   // NOTE: every combinational output gets a default before any branch, so an
   // idle cycle can never leave a path unassigned and infer a latch.
   always_comb begin
      sum_d   = sum_q;
      valid_d = 1'b0;
`ifdef PADDSB_SAT_FLAGS_EN
      sat_d   = sat_q;
`endif
      if (bus.in_valid) begin
         valid_d = 1'b1;
         for (int i = 0; i < LANES; i++) begin
            sum_d[i*LANE_W +: LANE_W] = lane_sat(bus.a[i*LANE_W +: LANE_W],
                                                 bus.b[i*LANE_W +: LANE_W],
                                                 bus.sub);
`ifdef PADDSB_SAT_FLAGS_EN
            sat_d[i] = lane_ovf(bus.a[i*LANE_W +: LANE_W],
                                bus.b[i*LANE_W +: LANE_W],
                                bus.sub);
`endif
         end
      end
   end

   // NOTE: state uses non-blocking assignments; reset is synchronous, so it
   // lives inside the clocked branch rather than the sensitivity list.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_q   <= '0;
         valid_q <= 1'b0;
`ifdef PADDSB_SAT_FLAGS_EN
         sat_q   <= '0;
`endif
      end else begin
         sum_q   <= sum_d;
         valid_q <= valid_d;
`ifdef PADDSB_SAT_FLAGS_EN
         sat_q   <= sat_d;
`endif
      end
   end

   assign bus.sum       = sum_q;
   assign bus.out_valid = valid_q;
`ifdef PADDSB_SAT_FLAGS_EN
   assign bus.sat_flags = sat_q;
   assign bus.any_sat   = |sat_q;
`endif

endmodule

// File: tb/tb_paddsb_16bit.sv
// Self-checking bench for paddsb_16bit: directed plan vectors plus randomized
// traffic against an integer-arithmetic reference model.
module tb_paddsb_16bit;
   logic clk;
   logic rst_n;

   paddsb_16bit_if bus ();

   paddsb_16bit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] exp_sum;
   logic        exp_valid;
   logic [3:0]  exp_flags;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: exact integer result per lane, clamped to -8..+7.
   function automatic logic [19:0] model(input logic [15:0] av, input logic [15:0] bv,
                                         input logic s);
      logic [15:0]       res;
      logic [3:0]        fl;
      logic signed [3:0] la, lb;
      int                r;
      res = '0;
      fl  = '0;
      for (int i = 0; i < 4; i++) begin
         la = av[4*i +: 4];
         lb = bv[4*i +: 4];
         r  = s ? (int'(la) - int'(lb)) : (int'(la) + int'(lb));
         if (r > 7) begin
            r = 7;
            fl[i] = 1'b1;
         end else if (r < -8) begin
            r = -8;
            fl[i] = 1'b1;
         end
         res[4*i +: 4] = 4'(r);
      end
      return {fl, res};
   endfunction

   task automatic step(input logic rst, input logic v, input logic s,
                       input logic [15:0] av, input logic [15:0] bv, input string tag);
      @(negedge clk);
      rst_n        = rst;
      bus.in_valid = v;
      bus.sub      = s;
      bus.a        = av;
      bus.b        = bv;
      @(posedge clk);
      #1;
      if (!rst) begin
         exp_sum   = '0;
         exp_valid = 1'b0;
         exp_flags = '0;
      end else if (v) begin
         {exp_flags, exp_sum} = model(av, bv, s);
         exp_valid = 1'b1;
      end else begin
         exp_valid = 1'b0;
      end
      check({tag, " sum"}, 32'(bus.sum), 32'(exp_sum));
      check({tag, " out_valid"}, 32'(bus.out_valid), 32'(exp_valid));
`ifdef PADDSB_SAT_FLAGS_EN
      check({tag, " sat_flags"}, 32'(bus.sat_flags), 32'(exp_flags));
      check({tag, " any_sat"}, 32'(bus.any_sat), 32'(|exp_flags));
`endif
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.sub      = 1'b0;
      bus.a        = '0;
      bus.b        = '0;
      exp_sum      = '0;
      exp_valid    = 1'b0;
      exp_flags    = '0;

      step(1'b0, 1'b1, 1'b0, 16'h7777, 16'h1111, "reset0");
      step(1'b0, 1'b1, 1'b0, 16'h7777, 16'h1111, "reset1");
      check("reset sum const", 32'(bus.sum), 32'h0000);
      check("reset valid const", 32'(bus.out_valid), 32'h0);
      step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, "post_reset_idle");

      step(1'b1, 1'b1, 1'b0, 16'h1234, 16'h1111, "add_plain");
      check("add_plain const", 32'(bus.sum), 32'h2345);
      step(1'b1, 1'b1, 1'b0, 16'h7777, 16'h1111, "add_sat_pos");
      check("add_sat_pos const", 32'(bus.sum), 32'h7777);
      step(1'b1, 1'b1, 1'b0, 16'h8888, 16'h8888, "add_sat_neg");
      check("add_sat_neg const", 32'(bus.sum), 32'h8888);
`ifdef PADDSB_SAT_FLAGS_EN
      check("add_sat_neg flags const", 32'(bus.sat_flags), 32'hF);
`endif
      step(1'b1, 1'b1, 1'b1, 16'h4444, 16'h1111, "sub_plain");
      check("sub_plain const", 32'(bus.sum), 32'h3333);
      step(1'b1, 1'b1, 1'b1, 16'h7777, 16'h8888, "sub_sat_pos");
      check("sub_sat_pos const", 32'(bus.sum), 32'h7777);
      step(1'b1, 1'b1, 1'b1, 16'h8888, 16'h7777, "sub_sat_neg");
      check("sub_sat_neg const", 32'(bus.sum), 32'h8888);
      step(1'b1, 1'b1, 1'b1, 16'h0000, 16'h8888, "sub_min");
      check("sub_min const", 32'(bus.sum), 32'h7777);
      step(1'b1, 1'b1, 1'b0, 16'h7F01, 16'h1F0F, "lane_iso");
      check("lane_iso const", 32'(bus.sum), 32'h7E00);
      step(1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h1234, "idle_hold");
      check("idle_hold const", 32'(bus.sum), 32'h7E00);
      check("idle_valid const", 32'(bus.out_valid), 32'h0);

      for (int k = 0; k < 400; k++) begin
         step(($urandom_range(0, 49) != 0),
              ($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)),
              16'($urandom), 16'($urandom), "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
